// File: rtl/pueo_surf_trig_decoder.sv
// Decodes per-SURF two-beat trigger messages (address, metadata) into a
// single AXI4-Stream trigger queue, lowest lane first, with drop counting.
module pueo_surf_trig_decoder #(
    parameter int NSURF = 32,
    parameter int NBIT  = 16
) (
    input  logic                  sysclk_i,
    input  logic                  rstn_i,
    input  logic                  runrst_i,
    input  logic [NSURF*NBIT-1:0] trigin_dat_i,
    input  logic                  trigin_dat_valid_i,
    input  logic [NSURF-1:0]      trigmask_i,
    output logic [31:0]           trig_tdata_o,
    output logic                  trig_tvalid_o,
    input  logic                  trig_tready_i,
    output logic [15:0]           overflow_count_o
);

    localparam int IW = 5;

    typedef enum logic {
        IDLE,
        META
    } lane_st_e;

    lane_st_e         st_q    [NSURF];
    lane_st_e         st_d    [NSURF];
    logic [14:0]      wip_q   [NSURF];
    logic [14:0]      wip_d   [NSURF];
    logic [14:0]      ent_a_q [NSURF];
    logic [14:0]      ent_a_d [NSURF];
    logic [7:0]       ent_m_q [NSURF];
    logic [7:0]       ent_m_d [NSURF];
    logic [NSURF-1:0] pend_q, pend_d;
    logic [NSURF-1:0] drop;
    logic [31:0]      tdata_q, tdata_d;
    logic             tvalid_q, tvalid_d;
    logic [15:0]      ovf_q, ovf_d;
    logic [16:0]      ovf_sum;

    logic             sel_vld;
    logic [IW-1:0]    sel_idx;
    logic [14:0]      sel_a;
    logic [7:0]       sel_m;
    logic             load;

    // Descending scan so the lowest pending lane wins.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        sel_a   = '0;
        sel_m   = '0;
        for (int i = NSURF - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                sel_vld = 1'b1;
                sel_idx = IW'(i);
                sel_a   = ent_a_q[i];
                sel_m   = ent_m_q[i];
            end
        end
    end

    assign load = sel_vld && (!tvalid_q || trig_tready_i);

    always_comb begin
        pend_d   = pend_q;
        drop     = '0;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        ovf_d    = ovf_q;
        ovf_sum  = {1'b0, ovf_q};
        for (int i = 0; i < NSURF; i++) begin
            st_d[i]    = st_q[i];
            wip_d[i]   = wip_q[i];
            ent_a_d[i] = ent_a_q[i];
            ent_m_d[i] = ent_m_q[i];
            if (load && sel_idx == IW'(i))
                pend_d[i] = 1'b0;
            if (trigmask_i[i]) begin
                st_d[i] = IDLE;
            end else if (trigin_dat_valid_i) begin
                unique case (st_q[i])
                    IDLE: begin
                        if (trigin_dat_i[NBIT*i+15]) begin
                            wip_d[i] = trigin_dat_i[NBIT*i +: 15];
                            st_d[i]  = META;
                        end
                    end
                    META: begin
                        st_d[i] = IDLE;
                        // Clear-by-load happened above, so this is a real collision.
                        if (pend_d[i]) begin
                            drop[i] = 1'b1;
                        end else begin
                            pend_d[i]  = 1'b1;
                            ent_a_d[i] = wip_q[i];
                            ent_m_d[i] = trigin_dat_i[NBIT*i +: 8];
                        end
                    end
                endcase
            end
            ovf_sum = ovf_sum + 17'(drop[i]);
        end
        ovf_d = ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];

        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = {3'b000, sel_idx, sel_m, 1'b0, sel_a};
        end else if (trig_tready_i) begin
            tvalid_d = 1'b0;
        end

        if (runrst_i) begin
            for (int i = 0; i < NSURF; i++) begin
                st_d[i]    = IDLE;
                wip_d[i]   = '0;
                ent_a_d[i] = '0;
                ent_m_d[i] = '0;
            end
            pend_d   = '0;
            tvalid_d = 1'b0;
            tdata_d  = '0;
            ovf_d    = '0;
        end
    end

    always_ff @(posedge sysclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < NSURF; i++) begin
                st_q[i]    <= IDLE;
                wip_q[i]   <= '0;
                ent_a_q[i] <= '0;
                ent_m_q[i] <= '0;
            end
            pend_q   <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            ovf_q    <= '0;
        end else begin
            for (int i = 0; i < NSURF; i++) begin
                st_q[i]    <= st_d[i];
                wip_q[i]   <= wip_d[i];
                ent_a_q[i] <= ent_a_d[i];
                ent_m_q[i] <= ent_m_d[i];
            end
            pend_q   <= pend_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            ovf_q    <= ovf_d;
        end
    end

    assign trig_tdata_o     = tdata_q;
    assign trig_tvalid_o    = tvalid_q;
    assign overflow_count_o = ovf_q;

endmodule

// File: tb/tb_pueo_surf_trig_decoder.sv
// Directed bench for pueo_surf_trig_decoder: decode, ordering, masking,
// backpressure/overflow, saturation and both resets.
module tb_pueo_surf_trig_decoder;

    localparam int NSURF = 32;
    localparam int NBIT  = 16;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  runrst;
    logic [NSURF*NBIT-1:0] dat;
    logic                  vld;
    logic [NSURF-1:0]      mask;
    logic [31:0]           tdata;
    logic                  tvalid;
    logic                  tready;
    logic [15:0]           ovf;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pueo_surf_trig_decoder #(.NSURF(NSURF), .NBIT(NBIT)) dut (
        .sysclk_i          (clk),
        .rstn_i            (rstn),
        .runrst_i          (runrst),
        .trigin_dat_i      (dat),
        .trigin_dat_valid_i(vld),
        .trigmask_i        (mask),
        .trig_tdata_o      (tdata),
        .trig_tvalid_o     (tvalid),
        .trig_tready_i     (tready),
        .overflow_count_o  (ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [NSURF-1:0] lanes, input logic [15:0] w);
        for (int i = 0; i < NSURF; i++)
            dat[i*NBIT +: NBIT] = lanes[i] ? w : 16'h0000;
        vld = 1'b1;
        tick();
        vld = 1'b0;
        dat = '0;
    endtask

    task automatic msg(input logic [NSURF-1:0] lanes,
                       input logic [15:0] a, input logic [15:0] m);
        send(lanes, a);
        repeat (3) tick();
        send(lanes, m);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rstn   = 1'b0;
        runrst = 1'b0;
        vld    = 1'b0;
        dat    = '0;
        mask   = '0;
        tready = 1'b1;
        #12;
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tdata", tdata, 32'h0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        #1 rstn = 1'b1;
        tick();

        // single lane decode and latency
        msg(32'h1, 16'h8010, 16'h00AA);
        chk("lat_t1", 32'(tvalid), 32'd0);
        tick();
        chk("lat_t2_valid", 32'(tvalid), 32'd1);
        chk("lat_t2_data", tdata, 32'h00AA0010);
        tick();
        chk("single_xfer_done", 32'(tvalid), 32'd0);

        // two lanes on the same beats, ascending order
        msg(32'h0000000A, 16'h8005, 16'h0011);
        tick();
        chk("ord_v1", 32'(tvalid), 32'd1);
        chk("ord_d1", tdata, 32'h01110005);
        tick();
        chk("ord_v3", 32'(tvalid), 32'd1);
        chk("ord_d3", tdata, 32'h03110005);
        tick();
        chk("ord_done", 32'(tvalid), 32'd0);

        // masked lane ignored
        mask = 32'h1;
        msg(32'h1, 16'h8010, 16'h00AA);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mask_novalid", 32'(tvalid), 32'd0);
        end
        chk("mask_ovf", 32'(ovf), 32'd0);
        mask = '0;

        // masking mid-message aborts it
        send(32'h40, 16'h8011);
        mask = 32'h40;
        tick();
        mask = '0;
        tick();
        send(32'h40, 16'h0022);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_novalid", 32'(tvalid), 32'd0);
        end

        // backpressure, pending, overflow
        tready = 1'b0;
        msg(32'h4, 16'h8001, 16'h0001);
        tick();
        chk("bp_v1", 32'(tvalid), 32'd1);
        chk("bp_d1", tdata, 32'h02010001);
        msg(32'h4, 16'h8002, 16'h0002);
        tick();
        chk("bp_hold", tdata, 32'h02010001);
        chk("bp_ovf0", 32'(ovf), 32'd0);
        msg(32'h4, 16'h8003, 16'h0003);
        tick();
        chk("bp_ovf1", 32'(ovf), 32'd1);
        chk("bp_hold2", tdata, 32'h02010001);
        tready = 1'b1;
        chk("bp_out1_v", 32'(tvalid), 32'd1);
        chk("bp_out1_d", tdata, 32'h02010001);
        tick();
        chk("bp_out2_v", 32'(tvalid), 32'd1);
        chk("bp_out2_d", tdata, 32'h02020002);
        tick();
        chk("bp_empty", 32'(tvalid), 32'd0);

        // async reset during META with tvalid high
        tready = 1'b0;
        msg(32'h1, 16'h8010, 16'h00AA);
        tick();
        chk("ar_pre_valid", 32'(tvalid), 32'd1);
        send(32'h1, 16'h8020);
        rstn = 1'b0;
        #1;
        chk("ar_tvalid", 32'(tvalid), 32'd0);
        chk("ar_tdata", tdata, 32'h0);
        chk("ar_ovf", 32'(ovf), 32'd0);
        #2 rstn = 1'b1;
        tick();
        send(32'h1, 16'h00AA);
        tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("ar_orphan_meta", 32'(tvalid), 32'd0);
        end
        msg(32'h1, 16'h8030, 16'h00BB);
        tick();
        chk("ar_after_v", 32'(tvalid), 32'd1);
        chk("ar_after_d", tdata, 32'h00BB0030);
        tick();

        // overflow counting across all lanes and saturation
        tready = 1'b0;
        repeat (2) begin
            send('1, 16'h8001);
            send('1, 16'h0001);
        end
        chk("sat_ovf31", 32'(ovf), 32'd31);
        repeat (2047) begin
            send('1, 16'h8001);
            send('1, 16'h0001);
        end
        chk("sat_ovf_max", 32'(ovf), 32'h0000FFFF);
        repeat (5) begin
            send('1, 16'h8001);
            send('1, 16'h0001);
        end
        chk("sat_ovf_hold", 32'(ovf), 32'h0000FFFF);
        chk("sat_tdata", tdata, 32'h00010001);

        // run reset beats a concurrent metadata beat
        send(32'h20, 16'h8009);
        runrst = 1'b1;
        send(32'h20, 16'h0009);
        runrst = 1'b0;
        chk("rr_tvalid", 32'(tvalid), 32'd0);
        chk("rr_tdata", tdata, 32'h0);
        chk("rr_ovf", 32'(ovf), 32'd0);
        tready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("rr_no_pending", 32'(tvalid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
